// File: rtl/way_age_tracker.sv
// ----------------------------------------------------------------------------
// way_age_tracker
//
// Tracks one saturating age counter per cache way. It feeds a downstream
// "select biggest" block, which picks the oldest valid way as the victim.
//
// - An internal tick fires once every TICK_PERIOD enabled cycles.
// - On each tick, every valid way ages by one.
// - An access or fill sets the way's age back to zero.
// - An invalidate clears the way's valid bit and its age.
//
// Ports:
//   clk_in               clock; all state changes on the rising edge
//   reset_in             synchronous active-high reset
//   tick_enable_in       advances the tick period counter
//   access_valid_in      access/hit event, one-hot way in access_way_in
//   fill_valid_in        fill event, one-hot way in fill_way_in
//   invalidate_valid_in  invalidate event, one-hot way in invalidate_way_in
//   way_flatted_out      ages, way i at [i*W +: W]
//   condition_out        per-way valid mask
//   all_valid_out        every way valid
//   tick_out             one-cycle pulse, registered copy of the internal tick
// ----------------------------------------------------------------------------
module way_age_tracker #(
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int unsigned NUM_WAY                  = 16,
  parameter int unsigned TICK_PERIOD              = 8
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic                                          tick_enable_in,
  input  logic                                          access_valid_in,
  input  logic [NUM_WAY-1:0]                            access_way_in,
  input  logic                                          fill_valid_in,
  input  logic [NUM_WAY-1:0]                            fill_way_in,
  input  logic                                          invalidate_valid_in,
  input  logic [NUM_WAY-1:0]                            invalidate_way_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]   way_flatted_out,
  output logic [NUM_WAY-1:0]                            condition_out,
  output logic                                          all_valid_out,
  output logic                                          tick_out
);

  localparam int unsigned W    = SINGLE_WAY_WIDTH_IN_BITS;
  // A period of 1 still needs a 1-bit counter; it simply stays at 0.
  localparam int unsigned CntW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(TICK_PERIOD - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [W-1:0]    AgeMax  = {W{1'b1}};
  localparam logic [W-1:0]    AgeOne  = W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CntW-1:0]    r_tick_cnt;
  logic               r_tick;
  logic [W-1:0]       r_age [NUM_WAY];
  logic [NUM_WAY-1:0] r_valid;
  logic               r_all_valid;

  // Next-state values
  logic [CntW-1:0]    w_tick_cnt_d;
  logic               w_tick;
  logic [W-1:0]       w_age_d [NUM_WAY];
  logic [NUM_WAY-1:0] w_valid_d;

  // Per-way events, with each event's valid already folded in
  logic [NUM_WAY-1:0] w_inv_hit;
  logic [NUM_WAY-1:0] w_fill_hit;
  logic [NUM_WAY-1:0] w_acc_hit;

  // --------------------------------------------------------------------------
  // Tick period counter
  // --------------------------------------------------------------------------
  always_comb begin
    w_tick       = 1'b0;
    w_tick_cnt_d = r_tick_cnt;
    if (tick_enable_in) begin
      if (r_tick_cnt == CntLast) begin
        w_tick       = 1'b1;
        w_tick_cnt_d = '0;
      end else begin
        w_tick_cnt_d = r_tick_cnt + CntOne;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-way event decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_inv_hit  = invalidate_way_in & {NUM_WAY{invalidate_valid_in}};
    w_fill_hit = fill_way_in       & {NUM_WAY{fill_valid_in}};
    // An access to an invalid way does nothing, so gate it with valid here.
    w_acc_hit  = access_way_in     & {NUM_WAY{access_valid_in}} & r_valid;
  end

  // --------------------------------------------------------------------------
  // Per-way age / valid next state
  // Priority: invalidate > fill > access > tick > hold.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_WAY; i++) begin
      w_age_d[i]   = r_age[i];
      w_valid_d[i] = r_valid[i];
      if (w_inv_hit[i]) begin
        w_valid_d[i] = 1'b0;
        w_age_d[i]   = '0;
      end else if (w_fill_hit[i]) begin
        // A refill of an already-valid way also restarts its age.
        w_valid_d[i] = 1'b1;
        w_age_d[i]   = '0;
      end else if (w_acc_hit[i]) begin
        w_age_d[i]   = '0;
      end else if (w_tick && r_valid[i] && (r_age[i] != AgeMax)) begin
        w_age_d[i]   = r_age[i] + AgeOne;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_tick_cnt  <= '0;
      r_tick      <= 1'b0;
      r_valid     <= '0;
      r_all_valid <= 1'b0;
      for (int i = 0; i < NUM_WAY; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      r_tick_cnt  <= w_tick_cnt_d;
      r_tick      <= w_tick;
      r_valid     <= w_valid_d;
      // Taken from the next-state mask so it lines up with condition_out.
      r_all_valid <= &w_valid_d;
      for (int i = 0; i < NUM_WAY; i++) begin
        r_age[i] <= w_age_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_WAY; g++) begin : g_flat
    assign way_flatted_out[g*W +: W] = r_age[g];
  end

  assign condition_out = r_valid;
  assign all_valid_out = r_all_valid;
  assign tick_out      = r_tick;

endmodule

// File: tb/tb_way_age_tracker.sv
module tb_way_age_tracker;

  localparam int W = 4;
  localparam int N = 16;
  localparam int P = 8;

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic             tick_enable_in;
  logic             access_valid_in;
  logic [N-1:0]     access_way_in;
  logic             fill_valid_in;
  logic [N-1:0]     fill_way_in;
  logic             invalidate_valid_in;
  logic [N-1:0]     invalidate_way_in;
  logic [W*N-1:0]   way_flatted_out;
  logic [N-1:0]     condition_out;
  logic             all_valid_out;
  logic             tick_out;

  int n_cmp = 0;
  int n_err = 0;

  way_age_tracker #(
    .SINGLE_WAY_WIDTH_IN_BITS(W),
    .NUM_WAY                 (N),
    .TICK_PERIOD             (P)
  ) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .tick_enable_in     (tick_enable_in),
    .access_valid_in    (access_valid_in),
    .access_way_in      (access_way_in),
    .fill_valid_in      (fill_valid_in),
    .fill_way_in        (fill_way_in),
    .invalidate_valid_in(invalidate_valid_in),
    .invalidate_way_in  (invalidate_way_in),
    .way_flatted_out    (way_flatted_out),
    .condition_out      (condition_out),
    .all_valid_out      (all_valid_out),
    .tick_out           (tick_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [W-1:0] age_of(input int i);
    return way_flatted_out[i*W +: W];
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    reset_in            = 1'b0;
    tick_enable_in      = 1'b0;
    access_valid_in     = 1'b0;
    access_way_in       = '0;
    fill_valid_in       = 1'b0;
    fill_way_in         = '0;
    invalidate_valid_in = 1'b0;
    invalidate_way_in   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
  endtask

  task automatic fill_one(input int w);
    fill_valid_in = 1'b1;
    fill_way_in   = '0;
    fill_way_in[w] = 1'b1;
    step();
    fill_valid_in = 1'b0;
    fill_way_in   = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (condition_out !== '0) begin
      n_err++; $display("FAIL reset_cond: got %h expected 0", condition_out);
    end
    n_cmp++;
    if (way_flatted_out !== '0) begin
      n_err++; $display("FAIL reset_ages: got %h expected 0", way_flatted_out);
    end
    n_cmp++;
    if (all_valid_out !== 1'b0 || tick_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: all_valid=%b tick=%b expected 0/0", all_valid_out, tick_out);
    end
  endtask

  task automatic test_fill_all();
    do_reset();
    for (int i = 0; i < N; i++) begin
      fill_one(i);
      if (i == N - 2) begin
        n_cmp++;
        if (condition_out !== 16'h7FFF || all_valid_out !== 1'b0) begin
          n_err++;
          $display("FAIL fill_15: cond=%h all_valid=%b expected 7fff/0",
                   condition_out, all_valid_out);
        end
      end
    end
    n_cmp++;
    if (condition_out !== 16'hFFFF) begin
      n_err++; $display("FAIL fill_all_cond: got %h expected ffff", condition_out);
    end
    n_cmp++;
    if (all_valid_out !== 1'b1) begin
      n_err++; $display("FAIL fill_all_valid: got %b expected 1", all_valid_out);
    end
    n_cmp++;
    if (way_flatted_out !== '0) begin
      n_err++; $display("FAIL fill_all_ages: got %h expected 0", way_flatted_out);
    end
  endtask

  task automatic test_tick_period();
    int pulses;
    int pos [3];
    do_reset();
    fill_one(3);
    pulses = 0;
    tick_enable_in = 1'b1;
    for (int k = 0; k < 3 * P; k++) begin
      step();
      if (tick_out === 1'b1) begin
        if (pulses < 3) pos[pulses] = k;
        pulses++;
      end
    end
    tick_enable_in = 1'b0;
    n_cmp++;
    if (pulses != 3) begin
      n_err++; $display("FAIL tick_pulses: got %0d expected 3", pulses);
    end else begin
      n_cmp++;
      if (pos[0] != 7 || pos[1] != 15 || pos[2] != 23) begin
        n_err++;
        $display("FAIL tick_spacing: got %0d,%0d,%0d expected 7,15,23", pos[0], pos[1], pos[2]);
      end
    end
    n_cmp++;
    if (age_of(3) !== 4'd3) begin
      n_err++; $display("FAIL tick_age3: got %0d expected 3", age_of(3));
    end
    n_cmp++;
    if (condition_out !== 16'h0008 || way_flatted_out !== 64'h0000_0000_0000_3000) begin
      n_err++;
      $display("FAIL tick_others: cond=%h ages=%h expected 0008/0000000000003000",
               condition_out, way_flatted_out);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    fill_one(5);
    tick_enable_in = 1'b1;
    for (int k = 0; k < 10 * P; k++) step();
    n_cmp++;
    if (age_of(5) !== 4'd10) begin
      n_err++; $display("FAIL sat_mid: got %0d expected 10", age_of(5));
    end
    for (int k = 0; k < 10 * P; k++) step();
    tick_enable_in = 1'b0;
    n_cmp++;
    if (age_of(5) !== 4'hF) begin
      n_err++; $display("FAIL sat_hold: got %0d expected 15", age_of(5));
    end
    // A refill of a valid way restarts its age.
    fill_one(5);
    n_cmp++;
    if (age_of(5) !== 4'd0 || condition_out !== 16'h0020) begin
      n_err++;
      $display("FAIL refill: age=%0d cond=%h expected 0/0020", age_of(5), condition_out);
    end
  endtask

  task automatic test_access_vs_tick();
    do_reset();
    fill_one(2);
    fill_one(7);
    tick_enable_in = 1'b1;
    for (int k = 0; k < 6 * P + 7; k++) step();
    n_cmp++;
    if (age_of(2) !== 4'd6 || age_of(7) !== 4'd6) begin
      n_err++;
      $display("FAIL pre_access: ages %0d/%0d expected 6/6", age_of(2), age_of(7));
    end
    // Tick counter now sits at 7, so the next enabled cycle fires a tick.
    access_valid_in  = 1'b1;
    access_way_in    = 16'h0004;
    step();
    access_valid_in  = 1'b0;
    access_way_in    = '0;
    tick_enable_in   = 1'b0;
    n_cmp++;
    if (age_of(2) !== 4'd0) begin
      n_err++; $display("FAIL access_beats_tick: got %0d expected 0", age_of(2));
    end
    n_cmp++;
    if (age_of(7) !== 4'd7 || tick_out !== 1'b1) begin
      n_err++;
      $display("FAIL tick_other_way: age7=%0d tick=%b expected 7/1", age_of(7), tick_out);
    end
  endtask

  task automatic test_fill_inv_access_invalid();
    do_reset();
    fill_one(4);
    fill_valid_in       = 1'b1;
    fill_way_in         = 16'h0010;
    invalidate_valid_in = 1'b1;
    invalidate_way_in   = 16'h0010;
    step();
    clear_inputs();
    n_cmp++;
    if (condition_out[4] !== 1'b0 || age_of(4) !== 4'd0) begin
      n_err++;
      $display("FAIL inv_beats_fill: valid=%b age=%0d expected 0/0", condition_out[4], age_of(4));
    end
    access_valid_in = 1'b1;
    access_way_in   = 16'h0200;
    step();
    clear_inputs();
    n_cmp++;
    if (condition_out !== 16'h0000 || age_of(9) !== 4'd0) begin
      n_err++;
      $display("FAIL access_invalid: cond=%h age9=%0d expected 0000/0", condition_out, age_of(9));
    end
  endtask

  task automatic test_reset_mid();
    int first;
    do_reset();
    fill_one(1);
    tick_enable_in = 1'b1;
    for (int k = 0; k < P + 5; k++) step();
    n_cmp++;
    if (age_of(1) !== 4'd1) begin
      n_err++; $display("FAIL mid_pre: age1=%0d expected 1", age_of(1));
    end
    // Reset must win over a same-cycle fill.
    reset_in      = 1'b1;
    fill_valid_in = 1'b1;
    fill_way_in   = 16'h0001;
    step();
    reset_in      = 1'b0;
    fill_valid_in = 1'b0;
    fill_way_in   = '0;
    n_cmp++;
    if (condition_out !== '0 || way_flatted_out !== '0 || all_valid_out !== 1'b0 ||
        tick_out !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: cond=%h ages=%h av=%b tick=%b expected all 0",
               condition_out, way_flatted_out, all_valid_out, tick_out);
    end
    first = -1;
    for (int k = 0; k < 3 * P; k++) begin
      step();
      if (tick_out === 1'b1 && first < 0) first = k;
    end
    tick_enable_in = 1'b0;
    n_cmp++;
    if (first != P - 1) begin
      n_err++; $display("FAIL mid_first_tick: got cycle %0d expected %0d", first, P - 1);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fill_all();
    test_tick_period();
    test_saturate();
    test_access_vs_tick();
    test_fill_inv_access_invalid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
